rf_wb_sched: RTL

//   Writeback scheduler for the 3-port register file (two dual-port rf memory

---
 rtl/rf_wb_sched_if.sv | 46 ++++
 rtl/rf_wb_sched.sv | 119 +++++++++++
 2 files changed

// File: rtl/rf_wb_sched_if.sv
// ---------------------------------------------------------------------------
// rf_wb_sched_if
//   Bundle between the pipeline writeback stage, the writeback scheduler
//   and the register-file write port.
//
//   req0_*   ALU/EX writeback request   (valid/addr/data in, ready out)
//   req1_*   load/MEM writeback request (valid/addr/data in, ready out)
//   rf_*     single RF write port driven by the scheduler
//   init_done  high once the RF zero-fill has finished
//
//   slave  : the scheduler's view (takes requests, drives the RF port)
//   master : the pipeline/RF side's view
// ---------------------------------------------------------------------------
interface rf_wb_sched_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6
);
    logic              req0_valid;
    logic              req0_ready;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;

    logic              req1_valid;
    logic              req1_ready;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;

    logic              rf_we;
    logic [ADDR_W-1:0] rf_w_addr;
    logic [DATA_W-1:0] rf_wdata;
    logic              init_done;

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output rf_we, rf_w_addr, rf_wdata, init_done
    );

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  rf_we, rf_w_addr, rf_wdata, init_done
    );
endinterface

// File: rtl/rf_wb_sched.sv
// ---------------------------------------------------------------------------
// rf_wb_sched
//   Writeback scheduler for the register file. Shares the single RF write
//   port between the ALU result (req0) and the load result (req1). Because
//   the RF arrays have no reset, every reset first sequences a zero-fill of
//   r1..r(2**ADDR_W-1) before any request is accepted.
//
//   Ports
//     clk   clock, all state changes on posedge
//     rst   synchronous active-high reset
//     bus   rf_wb_sched_if.slave:
//             req0/req1 valid/addr/data in, ready out (combinational)
//             rf_we/rf_w_addr/rf_wdata out (registered, 1-cycle latency)
//             init_done out (registered)
// ---------------------------------------------------------------------------
module rf_wb_sched #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 6,
    parameter int STARVE_MAX = 3
) (
    input  logic         clk,
    input  logic         rst,
    rf_wb_sched_if.slave bus
);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]        state_q,      state_d;
    logic [ADDR_W-1:0] init_addr_q,  init_addr_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              rf_we_q,      rf_we_d;
    logic [ADDR_W-1:0] rf_w_addr_q,  rf_w_addr_d;
    logic [DATA_W-1:0] rf_wdata_q,   rf_wdata_d;
    logic              init_done_q,  init_done_d;

    logic run;
    logic starved;
    logic grant0;
    logic grant1;

    // Arbitration. Readies are forced low while rst is high so a requester
    // never sees an acceptance that the reset is about to throw away.
    always_comb begin
        run     = (state_q == ST_RUN) && !rst;
        starved = (starve_cnt_q == STARVE_LIM);
        grant1  = run && bus.req1_valid && (!bus.req0_valid || starved);
        grant0  = run && bus.req0_valid && !grant1;
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        rf_we_d     = 1'b0;
        rf_w_addr_d = rf_w_addr_q;
        rf_wdata_d  = rf_wdata_q;
        init_done_d = init_done_q;

        if (state_q == ST_INIT) begin
            // init_addr wraps to 0 right after r(max) has been issued, which
            // marks the end of the zero-fill (r0 is never written).
            if (init_addr_q == '0) begin
                state_d     = ST_RUN;
                init_done_d = 1'b1;
            end else begin
                rf_we_d     = 1'b1;
                rf_w_addr_d = init_addr_q;
                rf_wdata_d  = '0;
                init_addr_d = init_addr_q + 1'b1;
            end
        end else if (grant0) begin
            rf_we_d     = (bus.req0_addr != '0);
            rf_w_addr_d = bus.req0_addr;
            rf_wdata_d  = bus.req0_data;
        end else if (grant1) begin
            rf_we_d     = (bus.req1_addr != '0);
            rf_w_addr_d = bus.req1_addr;
            rf_wdata_d  = bus.req1_data;
        end

        // Count consecutive cycles req1 waits; any cycle it is idle or
        // served breaks the streak.
        if (bus.req1_valid && !grant1) begin
            starve_cnt_d = starved ? starve_cnt_q : starve_cnt_q + 1'b1;
        end else begin
            starve_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_INIT;
            init_addr_q  <= ADDR_W'(1);
            starve_cnt_q <= '0;
            rf_we_q      <= 1'b0;
            rf_w_addr_q  <= '0;
            rf_wdata_q   <= '0;
            init_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_addr_q  <= init_addr_d;
            starve_cnt_q <= starve_cnt_d;
            rf_we_q      <= rf_we_d;
            rf_w_addr_q  <= rf_w_addr_d;
            rf_wdata_q   <= rf_wdata_d;
            init_done_q  <= init_done_d;
        end
    end

    assign bus.rf_we     = rf_we_q;
    assign bus.rf_w_addr = rf_w_addr_q;
    assign bus.rf_wdata  = rf_wdata_q;
    assign bus.init_done = init_done_q;
endmodule
